alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, sequential successor to the core's single-cycle combinational ALU.
- Add/sub/logic/shift/compare complete in one clock. Signed multiply (shift-add) and signed divide (restoring) are iterative over WIDTH cycles, sized for area.
- Sits in the execute stage. The control unit issues an operation with a start/done handshake and stalls the pipeline while busy.
- Every function drives every output, so no latched outputs.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be ≥ 4 and a power of 2.
- SHW, log2(WIDTH), derived: shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only when busy=0.
- func  in  4  operation select, captured with start.
- inA  in  WIDTH  signed operand A, captured with start.
- inB  in  WIDTH  signed operand B, captured with start.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; result outputs are updated on this cycle.
- result  out  WIDTH  primary result: sum, low product word, quotient, etc.
- result_hi  out  WIDTH  high product word (mul) or remainder (div); 0 for other functions.
- overflow  out  1  signed overflow or divide exception.
- zero  out  1  result == 0.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high: clk and reset as named above.
  - On reset: state=IDLE, busy=0, done=0, result=0, result_hi=0, overflow=0, zero=1.
  - Reset mid-operation aborts the operation. No done is produced for it.
  - Reset has priority over start.
- Function codes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 xor, 0111 slt, 1000 sll, 1001 srl, 1010 sra.
  - Shift amount is inB[SHW-1:0].
  - slt gives result=1 if inA<inB (signed), else 0.
  - Codes 1011–1111 are illegal: result=0, result_hi=0, overflow=0, zero=1, done pulses normally.
- States: IDLE, MUL, DIV.
  - IDLE with start=1 and a single-cycle func: outputs are registered at the next edge, done=1 for that one cycle, and the block stays in IDLE. Latency is 1.
  - IDLE with start=1 and func=mul: operand magnitudes and sign are latched, the counter is loaded with WIDTH, and the block goes to MUL with busy=1.
  - IDLE with start=1 and func=div:
    - If inB≠0, it goes to DIV with busy=1.
    - If inB=0, it short-circuits: next edge gives result=0, result_hi=inA, overflow=1, done=1, and the block stays in IDLE.
  - MUL/DIV: one iteration per cycle; the counter decrements.
    - On the cycle the counter reaches 0, sign correction is applied, outputs are written, done=1, busy=0, and the block returns to IDLE.
    - Total latency from the start edge to the done edge is WIDTH+1 cycles.
- Handshake:
  - start while busy=1 is ignored. Operands are not re-sampled.
  - start on the same cycle as done is legal only from IDLE (single-cycle ops permit back-to-back issue every cycle).
  - done is never asserted for two consecutive cycles of the same operation.
- Outputs hold their values between done pulses. zero is updated only with result.
- Arithmetic rules:
  - add/sub: result is modulo 2^WIDTH. overflow uses the standard sign rule (operands same sign / result different for add; operands differing in sign / result sign ≠ A for sub).
  - mul: the full 2·WIDTH signed product is {result_hi, result}. overflow=1 iff result_hi is not the sign-extension of result[WIDTH-1].
  - div: quotient truncates toward zero. Remainder takes the sign of the dividend.
    - MIN / -1 gives result=MIN, result_hi=0, overflow=1, with full latency.
  - Logic ops, shifts and slt: overflow=0, result_hi=0.
  - sra fills with inA[WIDTH-1]. srl/sll fill with 0.
  - A shift amount of 0 returns inA.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF+1: done at cycle 1, result=0x80000000, overflow=1, zero=0. Then sub 5−5: result=0, zero=1, overflow=0. Issue back-to-back on consecutive cycles.
- mul −7×6: busy for 32 cycles, done at cycle 33, result=−42, result_hi=0xFFFFFFFF, overflow=0. Then mul 0x10000×0x10000: result=0, result_hi=1, overflow=1, zero=1.
- div −17/5: done at cycle 33, result=−3, result_hi=−2, overflow=0. Also div 0x80000000/−1: result=0x80000000, overflow=1. Also div 9/0: done at cycle 1, result=0, result_hi=9, overflow=1.
- Pulse start with an add during a running mul: the add is ignored, the mul result is unchanged, and exactly one done occurs.
- Assert reset 10 cycles into a div: the next cycle shows busy=0, result=0, zero=1, no done. A following add 2+3 gives 5 at latency 1.
- Shifts: sra 0x80000000 by 4 gives 0xF8000000, srl gives 0x08000000, sll 1 by 31 gives 0x80000000. slt −1<1 gives 1. Illegal func 1111 gives result=0, zero=1, done pulse.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with a start/done handshake.
//   Single-cycle ops (add, sub, logic, shifts, slt) finish one edge after start.
//   Signed mul (shift-add) and signed div (restoring) iterate for WIDTH cycles
//   on operand magnitudes, then apply sign correction on the last iteration.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            request, sampled only while idle
//   func[3:0]        operation select (captured with start)
//   inA, inB         signed operands (captured with start)
//   busy             iterative operation in progress
//   done             one-cycle pulse; result outputs update on this cycle
//   result           sum / low product word / quotient / ...
//   result_hi        high product word or remainder, else 0
//   overflow         signed overflow or divide exception
//   zero             result == 0
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] FnAdd = 4'h0;
  localparam logic [3:0] FnSub = 4'h1;
  localparam logic [3:0] FnMul = 4'h2;
  localparam logic [3:0] FnDiv = 4'h3;
  localparam logic [3:0] FnAnd = 4'h4;
  localparam logic [3:0] FnOr  = 4'h5;
  localparam logic [3:0] FnXor = 4'h6;
  localparam logic [3:0] FnSlt = 4'h7;
  localparam logic [3:0] FnSll = 4'h8;
  localparam logic [3:0] FnSrl = 4'h9;
  localparam logic [3:0] FnSra = 4'ha;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  // Shared datapath: mul uses {acc_hi_q, acc_lo_q} as product/multiplier,
  // div uses acc_hi_q as partial remainder and acc_lo_q as dividend/quotient.
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opb_q;      // multiplicand or divisor magnitude
  logic             neg_q;      // product / quotient sign
  logic             neg_rem_q;  // remainder sign (dividend sign)
  logic             dovf_q;     // MIN / -1

  // Single-cycle results
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ov;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   sh;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    sh     = inB[SHW-1:0];
    sum    = inA + inB;
    diff   = inA - inB;
    a_neg  = inA[WIDTH-1];
    b_neg  = inB[WIDTH-1];
    abs_a  = a_neg ? (~inA + 1'b1) : inA;
    abs_b  = b_neg ? (~inB + 1'b1) : inB;
    sc_res = '0;
    sc_hi  = '0;
    sc_ov  = 1'b0;
    case (func)
      FnAdd: begin
        sc_res = sum;
        sc_ov  = (inA[WIDTH-1] == inB[WIDTH-1]) && (sum[WIDTH-1] != inA[WIDTH-1]);
      end
      FnSub: begin
        sc_res = diff;
        sc_ov  = (inA[WIDTH-1] != inB[WIDTH-1]) && (diff[WIDTH-1] != inA[WIDTH-1]);
      end
      // Only reaches here for a zero divisor: short-circuit exception.
      FnDiv: begin
        sc_hi = inA;
        sc_ov = 1'b1;
      end
      FnAnd: sc_res = inA & inB;
      FnOr:  sc_res = inA | inB;
      FnXor: sc_res = inA ^ inB;
      FnSlt: sc_res = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
      FnSll: sc_res = inA << sh;
      FnSrl: sc_res = inA >> sh;
      FnSra: sc_res = $unsigned($signed(inA) >>> sh);
      default: ;
    endcase
  end

  // Iteration step logic
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_iter;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_lo_q[WIDTH-1:1]};
    prod      = neg_q ? (~mul_next + 1'b1) : mul_next;
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    rem_next  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {acc_lo_q[WIDTH-2:0], div_ge};
    quo_fix   = neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_fix   = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    last_iter = (cnt_q == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dovf_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (func == FnMul) begin
              acc_hi_q <= '0;
              acc_lo_q <= abs_b;
              opb_q    <= abs_a;
              neg_q    <= a_neg ^ b_neg;
              cnt_q    <= CW'(WIDTH);
              busy     <= 1'b1;
              state_q  <= StMul;
            end else if ((func == FnDiv) && (inB != '0)) begin
              acc_hi_q  <= '0;
              acc_lo_q  <= abs_a;
              opb_q     <= abs_b;
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dovf_q    <= (inA == {1'b1, {(WIDTH-1){1'b0}}}) && (inB == '1);
              cnt_q     <= CW'(WIDTH);
              busy      <= 1'b1;
              state_q   <= StDiv;
            end else begin
              result    <= sc_res;
              result_hi <= sc_hi;
              overflow  <= sc_ov;
              zero      <= (sc_res == '0);
              done      <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_hi_q <= mul_next[2*WIDTH-1:WIDTH];
          acc_lo_q <= mul_next[WIDTH-1:0];
          cnt_q    <= cnt_q - CW'(1);
          if (last_iter) begin
            result    <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
            overflow  <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            zero      <= (prod[WIDTH-1:0] == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StDiv: begin
          acc_hi_q <= rem_next;
          acc_lo_q <= quo_next;
          cnt_q    <= cnt_q - CW'(1);
          if (last_iter) begin
            // MIN / -1 yields MIN naturally from the magnitude path; only flag it.
            result    <= quo_fix;
            result_hi <= rem_fix;
            overflow  <= dovf_q;
            zero      <= (quo_fix == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  func;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        overflow;
  logic        zero;

  int tests = 0;
  int fails = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .func      (func),
    .inA       (inA),
    .inB       (inB),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for done; sampled on negedges.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; func = f; inA = a; inB = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int dones;

    vecs.push_back('{4'h0, 32'h7FFFFFFF, 32'h00000001, 1,  32'h80000000, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{4'h1, 32'h00000005, 32'h00000005, 1,  32'h00000000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{4'h1, 32'h80000000, 32'h00000001, 1,  32'h7FFFFFFF, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{4'h2, 32'hFFFFFFF9, 32'h00000006, 33, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 32'h00010000, 32'h00010000, 33, 32'h00000000, 32'h00000001, 1'b1, 1'b1});
    vecs.push_back('{4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'hFFFFFFEF, 32'h00000005, 33, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{4'h3, 32'h00000007, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'h00000009, 32'h00000000, 1,  32'h00000000, 32'h00000009, 1'b1, 1'b1});
    vecs.push_back('{4'h4, 32'h0000F0F0, 32'h0000FF00, 1,  32'h0000F000, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 32'h0000F0F0, 32'h0000FF00, 1,  32'h0000FFF0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 32'h0000F0F0, 32'h0000FF00, 1,  32'h00000FF0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 1,  32'h00000001, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'h00000001, 32'hFFFFFFFF, 1,  32'h00000000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{4'hA, 32'h80000000, 32'h00000004, 1,  32'hF8000000, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h9, 32'h80000000, 32'h00000004, 1,  32'h08000000, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 32'h00000001, 32'h0000001F, 1,  32'h80000000, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 32'h00001234, 32'h00000020, 1,  32'h00001234, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{4'hF, 32'h00000123, 32'h00000456, 1,  32'h00000000, 32'h0, 1'b0, 1'b1});

    reset = 1'b1; start = 1'b0; func = 4'h0; inA = '0; inB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset result_hi", 64'(result_hi), 64'(0));
    chk("reset overflow", 64'(overflow), 64'(0));
    chk("reset zero", 64'(zero), 64'(1));
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 64'(bc), 64'(vecs[i].lat > 1 ? vecs[i].lat - 1 : 0));
      chk($sformatf("v%0d result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("v%0d result_hi", i), 64'(result_hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
      chk($sformatf("v%0d zero", i), 64'(zero), 64'(vecs[i].z));
      @(negedge clk);
      chk($sformatf("v%0d done single pulse", i), 64'(done), 64'(0));
      chk($sformatf("v%0d result held", i), 64'(result), 64'(vecs[i].res));
    end

    // Back-to-back single-cycle ops on consecutive cycles
    @(negedge clk);
    start = 1'b1; func = 4'h0; inA = 32'h7FFFFFFF; inB = 32'h1;
    @(negedge clk);
    chk("b2b add done", 64'(done), 64'(1));
    chk("b2b add result", 64'(result), 64'(32'h80000000));
    chk("b2b add overflow", 64'(overflow), 64'(1));
    func = 4'h1; inA = 32'h5; inB = 32'h5;
    @(negedge clk);
    start = 1'b0;
    chk("b2b sub done", 64'(done), 64'(1));
    chk("b2b sub result", 64'(result), 64'(0));
    chk("b2b sub zero", 64'(zero), 64'(1));
    chk("b2b sub overflow", 64'(overflow), 64'(0));

    // Start pulsed during a running mul is ignored
    @(negedge clk);
    start = 1'b1; func = 4'h2; inA = 32'hFFFFFFF9; inB = 32'h6;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        start = 1'b1; func = 4'h0; inA = 32'h1; inB = 32'h1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (lat == 0) lat = c;
      end
      @(negedge clk);
    end
    chk("ignored start done count", 64'(dones), 64'(1));
    chk("ignored start latency", 64'(lat), 64'(33));
    chk("ignored start mul result", 64'(result), 64'(32'hFFFFFFD6));
    chk("ignored start mul hi", 64'(result_hi), 64'(32'hFFFFFFFF));

    // Reset ten cycles into a div aborts it
    start = 1'b1; func = 4'h3; inA = 32'hFFFFFFEF; inB = 32'h5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort result", 64'(result), 64'(0));
    chk("abort zero", 64'(zero), 64'(1));
    chk("abort done", 64'(done), 64'(0));
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort no done", 64'(dones), 64'(0));
    run_op(4'h0, 32'h2, 32'h3, lat, bc);
    chk("post-abort add latency", 64'(lat), 64'(1));
    chk("post-abort add result", 64'(result), 64'(5));
    chk("post-abort add zero", 64'(zero), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
